// File: rtl/npe_seq.sv
// Layer sequencer for the NPE datapath: accepts a one-shot command, pulls operand
// beats from the feature buffer, strobes each output group and waits for its result.
module npe_seq #(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned FLUSH_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [3:0]           i_mode,
  input  logic [CNT_WIDTH-1:0] i_vec_len,
  input  logic [CNT_WIDTH-1:0] i_group_num,
  input  logic [6:0]           i_pe_mask,
  input  logic                 i_abort,
  input  logic                 i_src_rdy,
  input  logic                 i_result_vld,
  output logic                 o_rd_en,
  output logic                 o_mdata_vld,
  output logic                 o_clear,
  output logic [6:0]           o_pe_en,
  output logic                 o_conv_out,
  output logic                 o_fc_out,
  output logic                 o_max_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int unsigned FW = (FLUSH_CYCLES > 1)   ? $clog2(FLUSH_CYCLES)   : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] MODE_CONV = 2'd0;
  localparam logic [1:0] MODE_FC   = 2'd1;
  localparam logic [1:0] MODE_MAX  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACC, ST_FLUSH, ST_STROBE, ST_WAIT_RES, ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [CNT_WIDTH-1:0] vec_len_q, vec_len_d;
  logic [CNT_WIDTH-1:0] grp_num_q, grp_num_d;
  logic [6:0]           mask_q, mask_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0] grp_q, grp_d;
  logic [FW-1:0]        flush_q, flush_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 mdata_vld_q;
  logic                 clear_q, clear_d;
  logic [6:0]           pe_en_q, pe_en_d;
  logic                 conv_q, conv_d;
  logic                 fc_q, fc_d;
  logic                 max_q, max_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rd_en_c;
  logic [CNT_WIDTH-1:0] beat_inc, grp_inc;
  logic                 cmd_legal;

  assign beat_inc  = beat_q + CNT_WIDTH'(1);
  assign grp_inc   = grp_q + CNT_WIDTH'(1);
  assign cmd_legal = (i_mode < 4'd3) && (i_vec_len != '0) && (i_group_num != '0);

  // Next-state and registered-output decode; pulses are set on the transition
  // into the state in which they must be visible.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    vec_len_d = vec_len_q;
    grp_num_d = grp_num_q;
    mask_d    = mask_q;
    beat_d    = beat_q;
    grp_d     = grp_q;
    flush_d   = flush_q;
    tmo_d     = tmo_q;
    clear_d   = 1'b0;
    conv_d    = 1'b0;
    fc_d      = 1'b0;
    max_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_en_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (cmd_legal) begin
            mode_d    = i_mode[1:0];
            vec_len_d = i_vec_len;
            grp_num_d = i_group_num;
            mask_d    = i_pe_mask;
            beat_d    = '0;
            grp_d     = '0;
            clear_d   = 1'b1;
            state_d   = ST_ACC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ACC: begin
        rd_en_c = i_src_rdy && (beat_q < vec_len_q);
        if (rd_en_c) begin
          beat_d = beat_inc;
          if (beat_inc == vec_len_q) begin
            flush_d = '0;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q == FW'(FLUSH_CYCLES - 1)) begin
          state_d = ST_STROBE;
          case (mode_q)
            MODE_CONV: conv_d = 1'b1;
            MODE_FC:   fc_d   = 1'b1;
            MODE_MAX:  max_d  = 1'b1;
            default:   ;
          endcase
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      ST_STROBE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (i_result_vld) begin
          grp_d  = grp_inc;
          beat_d = '0;
          if (grp_inc == grp_num_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            clear_d = 1'b1;
            state_d = ST_ACC;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides every transition, including result and timeout in the same cycle.
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      clear_d = 1'b0;
      conv_d  = 1'b0;
      fc_d    = 1'b0;
      max_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    busy_d  = (state_d != ST_IDLE);
    pe_en_d = busy_d ? mask_d : 7'h00;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      vec_len_q   <= '0;
      grp_num_q   <= '0;
      mask_q      <= '0;
      beat_q      <= '0;
      grp_q       <= '0;
      flush_q     <= '0;
      tmo_q       <= '0;
      mdata_vld_q <= 1'b0;
      clear_q     <= 1'b0;
      pe_en_q     <= '0;
      conv_q      <= 1'b0;
      fc_q        <= 1'b0;
      max_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      vec_len_q   <= vec_len_d;
      grp_num_q   <= grp_num_d;
      mask_q      <= mask_d;
      beat_q      <= beat_d;
      grp_q       <= grp_d;
      flush_q     <= flush_d;
      tmo_q       <= tmo_d;
      mdata_vld_q <= rd_en_c;
      clear_q     <= clear_d;
      pe_en_q     <= pe_en_d;
      conv_q      <= conv_d;
      fc_q        <= fc_d;
      max_q       <= max_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_rd_en     = rd_en_c;
  assign o_mdata_vld = mdata_vld_q;
  assign o_clear     = clear_q;
  assign o_pe_en     = pe_en_q;
  assign o_conv_out  = conv_q;
  assign o_fc_out    = fc_q;
  assign o_max_out   = max_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_npe_seq.sv
// Directed bench for npe_seq: expected strobe/done/err events are queued with their
// cycle numbers when a command is driven, and popped as the DUT raises them.
module tb_npe_seq;

  localparam int unsigned CW = 16;
  localparam int unsigned FL = 4;
  localparam int unsigned TO = 255;

  localparam int EV_CONV = 1;
  localparam int EV_FC   = 2;
  localparam int EV_MAX  = 3;
  localparam int EV_DONE = 4;
  localparam int EV_ERR  = 5;

  logic          clk = 1'b0;
  logic          rst, start, abort, src_rdy, res_vld;
  logic [3:0]    mode;
  logic [CW-1:0] vl, gn;
  logic [6:0]    mask;
  logic          o_rd_en, o_mdata_vld, o_clear, o_conv_out, o_fc_out, o_max_out;
  logic          o_busy, o_done, o_err;
  logic [6:0]    o_pe_en;

  npe_seq #(.CNT_WIDTH(CW), .FLUSH_CYCLES(FL), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_vec_len(vl),
    .i_group_num(gn), .i_pe_mask(mask), .i_abort(abort), .i_src_rdy(src_rdy),
    .i_result_vld(res_vld), .o_rd_en(o_rd_en), .o_mdata_vld(o_mdata_vld),
    .o_clear(o_clear), .o_pe_en(o_pe_en), .o_conv_out(o_conv_out),
    .o_fc_out(o_fc_out), .o_max_out(o_max_out), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int kind; int cyc;} ev_t;
  ev_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int n_rd = 0, n_mdv = 0, n_clr = 0, n_pe_bad = 0, n_mdv_bad = 0;
  logic [6:0] exp_mask = 7'h00;
  logic rd_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic take_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, 0);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_rd_en === 1'b1) n_rd++;
    if (o_mdata_vld === 1'b1) n_mdv++;
    if (o_clear === 1'b1) n_clr++;
    if (o_pe_en !== (o_busy ? exp_mask : 7'h00)) n_pe_bad++;
    if (o_mdata_vld !== rd_prev) n_mdv_bad++;
    rd_prev = o_rd_en & ~rst;
    if (o_conv_out === 1'b1) take_ev(EV_CONV);
    if (o_fc_out === 1'b1) take_ev(EV_FC);
    if (o_max_out === 1'b1) take_ev(EV_MAX);
    if (o_done === 1'b1) take_ev(EV_DONE);
    if (o_err === 1'b1) take_ev(EV_ERR);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic until_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic issue(input logic [3:0] m, input int v, input int g, input logic [6:0] k);
    mode  = m;
    vl    = CW'(v);
    gn    = CW'(g);
    mask  = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_result();
    res_vld = 1'b1;
    tick();
    res_vld = 1'b0;
  endtask

  int s, s1, s2, t;
  int rd0, clr0, mdv0, pe0;
  logic rdy_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; src_rdy = 1'b0; res_vld = 1'b0;
    mode = '0; vl = '0; gn = '0; mask = '0;
    repeat (3) tick();
    chk("reset_outputs",
        {o_busy, o_done, o_err, o_clear, o_mdata_vld, o_conv_out, o_fc_out, o_max_out, o_pe_en}, 0);
    rst = 1'b0;
    tick();

    // Conv, 3 beats x 2 groups, result 2 cycles after each strobe
    exp_mask = 7'h7F; src_rdy = 1'b1;
    rd0 = n_rd; clr0 = n_clr; mdv0 = n_mdv; pe0 = n_pe_bad;
    s = cyc; s1 = s + 1 + 3 + FL;
    expect_ev(EV_CONV, s1);
    issue(4'd0, 3, 2, 7'h7F);
    chk("t1_first_clear", o_clear, 1);
    chk("t1_first_rd", o_rd_en, 1);
    until_cyc(s1 + 2);
    pulse_result();
    s2 = s1 + 3 + 3 + FL;
    expect_ev(EV_CONV, s2);
    expect_ev(EV_DONE, s2 + 3);
    until_cyc(s2 + 2);
    pulse_result();
    chk("t1_busy_at_done", o_busy, 1);
    tick();
    chk("t1_busy_after_done", o_busy, 0);
    chk("t1_rd_count", n_rd - rd0, 6);
    chk("t1_clear_count", n_clr - clr0, 2);
    chk("t1_mdata_count", n_mdv - mdv0, 6);
    chk("t1_pe_en", n_pe_bad - pe0, 0);

    // Same command with ready toggling 1,0,0,1,1 on the first group
    rd0 = n_rd;
    s = cyc; s1 = s + 5 + FL + 1;
    expect_ev(EV_CONV, s1);
    issue(4'd0, 3, 2, 7'h7F);
    for (int i = 0; i < 5; i++) begin
      src_rdy = rdy_pat[i];
      #1;
      chk("t2_rd_on_ready", o_rd_en, rdy_pat[i]);
      tick();
    end
    until_cyc(s1 + 2);
    pulse_result();
    s2 = s1 + 3 + 3 + FL;
    expect_ev(EV_CONV, s2);
    expect_ev(EV_DONE, s2 + 3);
    until_cyc(s2 + 2);
    pulse_result();
    tick();
    chk("t2_busy_after_done", o_busy, 0);
    chk("t2_rd_count", n_rd - rd0, 6);

    // Illegal commands are rejected with a single error pulse
    rd0 = n_rd;
    for (int i = 0; i < 3; i++) begin
      s = cyc;
      expect_ev(EV_ERR, s + 1);
      case (i)
        0:       issue(4'd5, 3, 2, 7'h7F);
        1:       issue(4'd0, 0, 2, 7'h7F);
        default: issue(4'd1, 3, 0, 7'h7F);
      endcase
      chk("t3_busy_low", o_busy, 0);
      chk("t3_no_rd", o_rd_en, 0);
      tick();
    end
    chk("t3_rd_count", n_rd - rd0, 0);

    // FC with no result: timeout error, then a fresh command runs normally
    exp_mask = 7'h0F;
    s = cyc;
    expect_ev(EV_FC, s + 1 + 2 + FL);
    expect_ev(EV_ERR, s + 1 + 2 + FL + 1 + TO);
    issue(4'd1, 2, 1, 7'h0F);
    until_cyc(s + 1 + 2 + FL + TO);
    chk("t4_busy_before_timeout", o_busy, 1);
    tick();
    tick();
    chk("t4_idle_after_timeout", o_busy, 0);
    t = cyc;
    expect_ev(EV_FC, t + 1 + 1 + FL);
    expect_ev(EV_DONE, t + 1 + 1 + FL + 2);
    issue(4'd1, 1, 1, 7'h0F);
    until_cyc(t + 1 + 1 + FL + 1);
    pulse_result();
    tick();
    chk("t4_restart_idle", o_busy, 0);

    // Abort during FLUSH: no strobe, no done, no error
    exp_mask = 7'h33;
    s = cyc;
    issue(4'd0, 2, 1, 7'h33);
    until_cyc(s + 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_idle", o_busy, 0);
    chk("t5_abort_pe_en", o_pe_en, 0);
    repeat (15) tick();

    // Reset during ACC clears everything on the next edge
    exp_mask = 7'h55;
    s = cyc;
    issue(4'd0, 5, 1, 7'h55);
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_outputs",
        {o_busy, o_done, o_err, o_clear, o_rd_en, o_mdata_vld, o_conv_out, o_fc_out, o_max_out, o_pe_en}, 0);
    rst = 1'b0;
    repeat (20) tick();

    // Max mode with a re-start while busy and a spurious result during ACC
    exp_mask = 7'h15; rd0 = n_rd;
    s = cyc; s1 = s + 1 + 2 + FL;
    expect_ev(EV_MAX, s1);
    issue(4'd2, 2, 2, 7'h15);
    start = 1'b1; mode = 4'd0; vl = CW'(7); res_vld = 1'b1;
    tick();
    start = 1'b0; res_vld = 1'b0;
    until_cyc(s1 + 2);
    pulse_result();
    s2 = s1 + 3 + 2 + FL;
    expect_ev(EV_MAX, s2);
    expect_ev(EV_DONE, s2 + 3);
    until_cyc(s2 + 2);
    pulse_result();
    tick();
    chk("t6_busy_after_done", o_busy, 0);
    chk("t6_rd_count", n_rd - rd0, 4);

    repeat (5) tick();
    chk("mdata_follows_rd", n_mdv_bad, 0);
    chk("pe_en_tracks_busy", n_pe_bad, 0);
    chk("events_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/npe_seq.md
# npe_seq

Layer sequencer for the NPE datapath. Takes a one-shot command (mode, beats per output group, group count, PE mask), pulls operand beats from the feature buffer under a ready/enable handshake, and drives the NPE's valid, clear, PE-enable and output-strobe controls. It waits for each group's result before starting the next, then reports completion or error to the top-level scheduler.

## Interface
- CNT_WIDTH, 16, width of beat and group counters
- FLUSH_CYCLES, 4, idle cycles after last beat before output strobe (NPE pipeline depth)
- TIMEOUT_CYCLES, 255, max cycles waiting for i_result_vld
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  command strobe, sampled only in IDLE
- i_mode  in  4  0=conv, 1=fc, 2=max; others illegal
- i_vec_len  in  CNT_WIDTH  beats per output group
- i_group_num  in  CNT_WIDTH  output groups per command
- i_pe_mask  in  7  PE enable mask
- i_abort  in  1  abandon command
- i_src_rdy  in  1  buffer has a beat available
- i_result_vld  in  1  NPE result valid (o_npe_result_vld)
- o_rd_en  out  1  buffer read, combinational
- o_mdata_vld  out  1  operand valid to NPE, registered
- o_clear  out  1  accumulator clear pulse
- o_pe_en  out  7  latched mask; 0 outside a command
- o_conv_out / o_fc_out / o_max_out  out  1 each  output strobes
- o_busy  out  1  high in any state but IDLE
- o_done  out  1  completion pulse
- o_err  out  1  error pulse (reject or timeout)

## Operation
- States: IDLE, ACC, FLUSH, STROBE, WAIT_RES, DONE.
- IDLE + i_start:
  - If mode is legal and vec_len≠0 and group_num≠0: latch mode, vec_len, group_num and mask, and go to ACC.
  - Otherwise pulse o_err for 1 cycle and stay in IDLE.
- i_start outside IDLE is ignored.
- ACC:
  - o_clear=1 on the first ACC cycle of each group only.
  - o_rd_en = (state==ACC) & i_src_rdy & (beat_cnt<vec_len).
  - Each o_rd_en increments beat_cnt.
  - When beat_cnt reaches vec_len, go to FLUSH. Stalls on i_src_rdy=0 are unbounded.
- FLUSH: count FLUSH_CYCLES cycles, then go to STROBE.
- STROBE: 1-cycle pulse on the strobe selected by the latched mode (conv→o_conv_out, fc→o_fc_out, max→o_max_out), then go to WAIT_RES.
- WAIT_RES:
  - On i_result_vld, increment grp_cnt and clear beat_cnt.
  - If grp_cnt equals group_num, go to DONE; else go to ACC.
  - If TIMEOUT_CYCLES pass without i_result_vld: pulse o_err, go to IDLE.
- DONE: o_done=1 for 1 cycle, then go to IDLE.
- i_abort in any non-IDLE state: go to IDLE next cycle, with no o_done and no o_err.
- i_result_vld outside WAIT_RES is ignored.
- Counters are CNT_WIDTH unsigned, compared for equality, and never wrap within a legal command.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-command: everything returns to reset values on the next edge.
- o_mdata_vld = o_rd_en delayed 1 cycle (1-cycle buffer read latency).
- i_start sampled at edge N → ACC at N+1; with i_src_rdy=1, o_clear and the first o_rd_en are both in cycle N+1.
- Last beat read at cycle M:
  - FLUSH occupies M+1 … M+FLUSH_CYCLES.
  - Strobe at M+FLUSH_CYCLES+1.
  - WAIT_RES from M+FLUSH_CYCLES+2.
- i_result_vld at cycle R on the last group → o_done at R+1, o_busy low at R+2.
- o_pe_en equals the latched mask while o_busy=1, else 0.
- Simultaneous i_abort and i_result_vld: abort wins.
- Simultaneous i_abort and timeout: abort wins, no o_err.

## Test plan
- Conv, vec_len=3, group_num=2, mask=7'h7F, i_src_rdy=1, result returned 2 cycles after strobe -> o_rd_en 3 cycles per group, o_clear twice, o_conv_out twice, exactly 6 o_mdata_vld, o_done once, o_pe_en=7F throughout.
- Same command with i_src_rdy toggling 1,0,0,1,1 -> 3 reads taken only on ready cycles; strobe exactly FLUSH_CYCLES+1 after the 3rd read.
- Illegal commands (mode=5; vec_len=0; group_num=0) -> o_err 1 cycle each, o_busy stays 0, no o_rd_en.
- FC, no i_result_vld after strobe -> o_err exactly TIMEOUT_CYCLES after WAIT_RES entry, then IDLE; a new start is accepted.
- i_abort during FLUSH; then i_rst during ACC -> immediate IDLE, all outputs 0, no o_done, no late strobe.
- Max mode with i_start re-asserted while busy, and a spurious i_result_vld during ACC -> second start ignored, o_max_out only, group count unaffected.
